// File: rtl/seg_display_mux.sv
// Multiplexed active-low 7-segment driver with a shadow register, leading-zero
// blanking and hex/decimal glyphs. Optional SEG_BLINK_EN adds per-digit blinking.
module seg_display_mux #(
    parameter int NUM_DIGITS = 4,
    parameter int CLK_DIV    = 50000,
    parameter int HEX_MODE   = 0
`ifdef SEG_BLINK_EN
    ,
    parameter int BLINK_SCANS = 64
`endif
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [4*NUM_DIGITS-1:0] digits,
    input  logic [NUM_DIGITS-1:0]   dp,
    input  logic                    load,
    input  logic                    blank_lz,
    input  logic                    enable,
`ifdef SEG_BLINK_EN
    input  logic [NUM_DIGITS-1:0]   blink_mask,
`endif
    output logic [7:0]              seg,
    output logic [NUM_DIGITS-1:0]   an,
    output logic                    scan_done
);

    localparam int IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    localparam int DIV_W = $clog2(CLK_DIV);
    localparam logic [IDX_W-1:0] IDX_MAX = IDX_W'(NUM_DIGITS - 1);
    localparam logic [DIV_W-1:0] DIV_MAX = DIV_W'(CLK_DIV - 1);

    logic [DIV_W-1:0]        r_div;
    logic [IDX_W-1:0]        r_idx;
    logic [4*NUM_DIGITS-1:0] r_sh_dig;
    logic [NUM_DIGITS-1:0]   r_sh_dp;
    logic [7:0]              r_seg;
    logic [NUM_DIGITS-1:0]   r_an;
    logic                    r_done;

    logic                    w_tick;
    logic [3:0]              w_nib;
    logic                    w_dp;
    logic                    w_nz;
    logic                    w_blank;
    logic                    w_blink;
    logic [7:0]              w_seg;
    logic [NUM_DIGITS-1:0]   w_an;

    function automatic logic [6:0] glyph(input logic [3:0] v);
        logic [6:0] g;
        case (v)
            4'h0: g = 7'h40;
            4'h1: g = 7'h79;
            4'h2: g = 7'h24;
            4'h3: g = 7'h30;
            4'h4: g = 7'h19;
            4'h5: g = 7'h12;
            4'h6: g = 7'h02;
            4'h7: g = 7'h78;
            4'h8: g = 7'h00;
            4'h9: g = 7'h10;
            4'hA: g = (HEX_MODE != 0) ? 7'h08 : 7'h3F;
            4'hB: g = (HEX_MODE != 0) ? 7'h03 : 7'h3F;
            4'hC: g = (HEX_MODE != 0) ? 7'h46 : 7'h3F;
            4'hD: g = (HEX_MODE != 0) ? 7'h21 : 7'h3F;
            4'hE: g = (HEX_MODE != 0) ? 7'h06 : 7'h3F;
            default: g = (HEX_MODE != 0) ? 7'h0E : 7'h3F;
        endcase
        return g;
    endfunction

    assign w_tick = (r_div == DIV_MAX);

`ifdef SEG_BLINK_EN
    localparam int BC_W = (BLINK_SCANS > 1) ? $clog2(BLINK_SCANS) : 1;
    localparam logic [BC_W-1:0] BC_MAX = BC_W'(BLINK_SCANS - 1);
    logic [BC_W-1:0] r_bcnt;
    logic            r_phase;

    // Phase flips once every BLINK_SCANS completed scans.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_bcnt  <= '0;
            r_phase <= 1'b0;
        end else if (w_tick && (r_idx == '0)) begin
            if (r_bcnt == BC_MAX) begin
                r_bcnt  <= '0;
                r_phase <= ~r_phase;
            end else begin
                r_bcnt <= r_bcnt + 1'b1;
            end
        end
    end
`endif

    // Everything the next tick needs is decoded from the shadow, never the live inputs.
    always_comb begin
        w_nib   = 4'h0;
        w_dp    = 1'b0;
        w_nz    = 1'b0;
        w_blink = 1'b0;
        w_an    = '1;
        for (int j = 0; j < NUM_DIGITS; j++) begin
            if (IDX_W'(j) == r_idx) begin
                w_nib   = r_sh_dig[j*4 +: 4];
                w_dp    = r_sh_dp[j];
                w_an[j] = 1'b0;
`ifdef SEG_BLINK_EN
                w_blink = r_phase & blink_mask[j];
`endif
            end
            if ((IDX_W'(j) >= r_idx) && (r_sh_dig[j*4 +: 4] != 4'h0))
                w_nz = 1'b1;
        end
        w_blank = blank_lz && (r_idx != '0) && !w_nz;
        if (w_blink)
            w_seg = 8'hFF;
        else if (w_blank)
            w_seg = {~w_dp, 7'h7F};
        else
            w_seg = {~w_dp, glyph(w_nib)};
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_div    <= '0;
            r_idx    <= IDX_MAX;
            r_sh_dig <= '0;
            r_sh_dp  <= '0;
        end else begin
            r_div <= w_tick ? '0 : r_div + 1'b1;
            if (w_tick)
                r_idx <= (r_idx == '0) ? IDX_MAX : r_idx - 1'b1;
            if (load) begin
                r_sh_dig <= digits;
                r_sh_dp  <= dp;
            end
        end
    end

    // Disable darkens the pins on every edge; scanning and scan_done keep going.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_seg  <= 8'hFF;
            r_an   <= '1;
            r_done <= 1'b0;
        end else begin
            r_done <= w_tick && (r_idx == '0);
            if (!enable) begin
                r_seg <= 8'hFF;
                r_an  <= '1;
            end else if (w_tick) begin
                r_seg <= w_seg;
                r_an  <= w_an;
            end
        end
    end

    assign seg       = r_seg;
    assign an        = r_an;
    assign scan_done = r_done;

endmodule

// File: tb/tb_seg_display_mux.sv
// Directed bench for seg_display_mux, NUM_DIGITS=4, CLK_DIV=4; a second
// instance with HEX_MODE=1 checks the hex glyphs on the same stimulus.
module tb_seg_display_mux;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [15:0] digits = 16'h0;
    logic [3:0]  dp = 4'h0;
    logic        load = 1'b0;
    logic        blank_lz = 1'b0;
    logic        enable = 1'b1;
    logic [7:0]  seg, seg_h;
    logic [3:0]  an, an_h;
    logic        scan_done, done_h;

    int n_cmp = 0;
    int n_bad = 0;
    int cyc   = 0;

    seg_display_mux #(.NUM_DIGITS(4), .CLK_DIV(4), .HEX_MODE(0)) dut (
        .clk(clk), .rst(rst), .digits(digits), .dp(dp), .load(load),
        .blank_lz(blank_lz), .enable(enable),
        .seg(seg), .an(an), .scan_done(scan_done)
    );

    seg_display_mux #(.NUM_DIGITS(4), .CLK_DIV(4), .HEX_MODE(1)) dut_hex (
        .clk(clk), .rst(rst), .digits(digits), .dp(dp), .load(load),
        .blank_lz(blank_lz), .enable(enable),
        .seg(seg_h), .an(an_h), .scan_done(done_h)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h (cyc %0d)", tag, got, exp, cyc);
        end
    endtask

    task automatic step(input int n);
        for (int k = 0; k < n; k++) begin
            @(posedge clk);
            #1;
            cyc++;
        end
    endtask

    // Advance to the next multiple of CLK_DIV cycles since reset release.
    task automatic next_tick();
        step(1);
        while (cyc % 4 != 0) step(1);
    endtask

    task automatic slot(input string tag, input logic [3:0] e_an, input logic [7:0] e_seg,
                        input logic e_done);
        next_tick();
        chk({tag, ".an"}, 32'(an), 32'(e_an));
        chk({tag, ".seg"}, 32'(seg), 32'(e_seg));
        chk({tag, ".done"}, 32'(scan_done), 32'(e_done));
    endtask

    initial begin
        // Reset state
        #2 rst = 1'b1;
        #1;
        chk("rst.seg", 32'(seg), 32'hFF);
        chk("rst.an", 32'(an), 32'hF);
        chk("rst.done", 32'(scan_done), 32'h0);
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst = 1'b0; cyc = 0;

        // Scenario 1: basic scan of 1234
        digits = 16'h1234; dp = 4'h0; load = 1'b1;
        step(1);
        load = 1'b0;
        step(1);
        chk("s1.pre_an", 32'(an), 32'hF);
        slot("s1.d3", 4'b0111, 8'hF9, 1'b0);
        slot("s1.d2", 4'b1011, 8'hA4, 1'b0);
        slot("s1.d1", 4'b1101, 8'hB0, 1'b0);
        slot("s1.d0", 4'b1110, 8'h99, 1'b1);
        step(1);
        chk("s1.done_pulse", 32'(scan_done), 32'h0);
        chk("s1.hold_an", 32'(an), 32'hE);
        slot("s1.d3b", 4'b0111, 8'hF9, 1'b0);

        // Scenario 2: glyph modes and dp (cyc 20)
        digits = 16'hA000; dp = 4'b0001; load = 1'b1;
        step(1);
        load = 1'b0;
        slot("s2.d2", 4'b1011, 8'hC0, 1'b0);
        slot("s2.d1", 4'b1101, 8'hC0, 1'b0);
        slot("s2.d0dp", 4'b1110, 8'h40, 1'b1);
        slot("s2.d3dec", 4'b0111, 8'hBF, 1'b0);
        chk("s2.d3hex", 32'(seg_h), 32'h88);

        // Scenario 3: leading-zero blanking (cyc 36)
        blank_lz = 1'b1; digits = 16'h0050; dp = 4'h0; load = 1'b1;
        step(1);
        load = 1'b0;
        slot("s3.d2", 4'b1011, 8'hFF, 1'b0);
        slot("s3.d1", 4'b1101, 8'h92, 1'b0);
        slot("s3.d0", 4'b1110, 8'hC0, 1'b1);
        slot("s3.d3", 4'b0111, 8'hFF, 1'b0);
        digits = 16'h0000; dp = 4'b0100; load = 1'b1;
        step(1);
        load = 1'b0;
        slot("s3.z2dp", 4'b1011, 8'h7F, 1'b0);
        slot("s3.z1", 4'b1101, 8'hFF, 1'b0);
        slot("s3.z0", 4'b1110, 8'hC0, 1'b1);
        slot("s3.z3", 4'b0111, 8'hFF, 1'b0);

        // Scenario 4: load on the same edge as the tick for digit 2 (cyc 68)
        blank_lz = 1'b0;
        step(3);
        digits = 16'h5678; dp = 4'h0; load = 1'b1;
        step(1);
        load = 1'b0;
        chk("s4.old.an", 32'(an), 32'hB);
        chk("s4.old.seg", 32'(seg), 32'h40);
        slot("s4.d1", 4'b1101, 8'hF8, 1'b0);
        slot("s4.d0", 4'b1110, 8'h80, 1'b1);
        slot("s4.d3", 4'b0111, 8'h92, 1'b0);
        slot("s4.d2", 4'b1011, 8'h82, 1'b0);

        // Scenario 5: enable low mid-scan (cyc 88)
        step(2);
        enable = 1'b0;
        step(1);
        chk("s5.off.an", 32'(an), 32'hF);
        chk("s5.off.seg", 32'(seg), 32'hFF);
        step(4);
        chk("s5.done_lo", 32'(scan_done), 32'h0);
        step(1);
        chk("s5.done96", 32'(scan_done), 32'h1);
        chk("s5.dark_an", 32'(an), 32'hF);
        step(1);
        chk("s5.done97", 32'(scan_done), 32'h0);
        step(15);
        chk("s5.done112", 32'(scan_done), 32'h1);
        step(1);
        enable = 1'b1;
        step(2);
        chk("s5.hold_dark", 32'(an), 32'hF);
        slot("s5.resume", 4'b0111, 8'h92, 1'b0);

        // Scenario 6: async reset between edges (cyc 116)
        step(2);
        #2 rst = 1'b1;
        #1;
        chk("s6.an", 32'(an), 32'hF);
        chk("s6.seg", 32'(seg), 32'hFF);
        chk("s6.done", 32'(scan_done), 32'h0);
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst = 1'b0; cyc = 0;
        step(3);
        chk("s6.pre_an", 32'(an), 32'hF);
        slot("s6.first", 4'b0111, 8'hC0, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #20000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1, "timeout");
    end

endmodule
